// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the BCD display scanner: segment patterns (active-low, gfedcba),
// digit-slot index encoding and active-low one-hot anode patterns.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        DIG_UNITS    = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } dig_idx_t;

    localparam logic [2:0] AN_UNITS    = 3'b110;
    localparam logic [2:0] AN_TENS     = 3'b101;
    localparam logic [2:0] AN_HUNDREDS = 3'b011;
    localparam logic [2:0] AN_OFF      = 3'b111;

    // A nibble that cannot be a decimal digit.
    function automatic logic nib_bad(input logic [3:0] nib);
        return (nib > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Valid/ready input channel carrying a 2-digit packed BCD sum plus the hundreds carry.
interface bcd_display_scan_if;
    logic [7:0] sum;
    logic       carry;
    logic       sum_valid;
    logic       sum_ready;

    modport master (output sum, output carry, output sum_valid, input sum_ready);
    modport slave  (input sum, input carry, input sum_valid, output sum_ready);
endinterface

// File: rtl/bcd_display_scan_seg7.sv
// Combinational BCD to 7-segment decoder, active-low gfedcba; non-decimal codes show 'E'.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_E;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Three-digit multiplexed 7-segment scanner with a one-deep pending buffer that only
// updates the shown value on frame boundaries. Define BCD_DISP_LZB_EN for leading-zero blanking.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    bcd_display_scan_if.slave        s_in,
    output logic [2:0]               an,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic                     err
);

    localparam int              DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] r_div;
    dig_idx_t         r_idx;
    dig_idx_t         w_idx_next;
    logic             w_tick;
    logic             w_frame;
    logic             w_xfer;

    logic             r_pend_full;
    logic [8:0]       r_pend;
    logic [8:0]       r_disp;

    logic [2:0]       w_an_next;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_dec;
    logic [6:0]       w_seg_next;
    logic [1:0]       w_nib_bad;
    logic             w_err;

    logic [2:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_err;

    assign w_tick  = (r_div == DIV_LAST);
    assign w_frame = w_tick && (r_idx == DIG_HUNDREDS);

    // Ready depends only on buffer state; it is also held low while reset is applied.
    assign s_in.sum_ready = !r_pend_full && !rst;
    assign w_xfer         = s_in.sum_valid && s_in.sum_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= DIG_UNITS;
        end else begin
            r_idx <= w_idx_next;
        end
    end

    always_comb begin
        w_idx_next = r_idx;
        w_an_next  = AN_OFF;
        case (r_idx)
            DIG_UNITS: begin
                w_an_next = AN_UNITS;
                if (w_tick) w_idx_next = DIG_TENS;
            end
            DIG_TENS: begin
                w_an_next = AN_TENS;
                if (w_tick) w_idx_next = DIG_HUNDREDS;
            end
            DIG_HUNDREDS: begin
                w_an_next = AN_HUNDREDS;
                if (w_tick) w_idx_next = DIG_UNITS;
            end
            default: w_idx_next = DIG_UNITS;
        endcase
    end

    // A transfer can only happen with the buffer empty, so it never collides with the
    // boundary move; a value landing on a boundary waits for the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_full <= 1'b0;
            r_pend      <= '0;
            r_disp      <= '0;
        end else begin
            if (w_frame && r_pend_full) begin
                r_disp      <= r_pend;
                r_pend_full <= 1'b0;
            end
            if (w_xfer) begin
                r_pend      <= {s_in.carry, s_in.sum};
                r_pend_full <= 1'b1;
            end
        end
    end

    always_comb begin
        w_digit = '0;
        case (r_idx)
            DIG_UNITS:    w_digit = r_disp[3:0];
            DIG_TENS:     w_digit = r_disp[7:4];
            DIG_HUNDREDS: w_digit = {3'b000, r_disp[8]};
            default:      w_digit = '0;
        endcase
    end

    bcd_to_seg7 u_seg7 (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_nib_chk
            assign w_nib_bad[gi] = nib_bad(r_disp[gi*4 +: 4]);
        end
    endgenerate

    assign w_err = |w_nib_bad;

`ifdef BCD_DISP_LZB_EN
    logic w_blank;

    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            DIG_HUNDREDS: w_blank = !r_disp[8];
            DIG_TENS:     w_blank = !r_disp[8] && (r_disp[7:4] == 4'd0);
            default:      w_blank = 1'b0;
        endcase
    end

    assign w_seg_next = w_blank ? SEG_BLANK : w_seg_dec;
`else
    assign w_seg_next = w_seg_dec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
            r_err <= 1'b0;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_err <= w_err;
            r_dp  <= !(w_err && (r_idx == DIG_UNITS));
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;
    assign err = r_err;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan at REFRESH_DIV=4: frame-by-frame scan checks with
// hand-computed segment patterns, handshake stalls, error display and mid-frame reset.
module tb_bcd_display_scan;

    localparam int DIV = 4;

`ifdef BCD_DISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] LZ = LZB ? BL : S0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       err;
    logic       ready_s = 1'b0;
    logic [8:0] q[$];
    int         checks = 0;
    int         errors = 0;

    bcd_display_scan_if bus ();

    bcd_display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .s_in (bus),
        .an   (an),
        .seg  (seg),
        .dp   (dp),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: resolve the handshake on the rising edge, then present the queue head.
    task automatic step();
        logic acc;
        @(posedge clk);
        #1;
        acc = bus.sum_valid && ready_s;
        if (acc) begin
            $display("xfer carry=%0b sum=%02h", bus.carry, bus.sum);
            void'(q.pop_front());
            bus.sum_valid = 1'b0;
        end
        @(negedge clk);
        if (acc) check_eq("ready_low_after_xfer", 32'(bus.sum_ready), 32'd0);
        ready_s = bus.sum_ready;
        if (q.size() > 0) begin
            bus.sum_valid          = 1'b1;
            {bus.carry, bus.sum}   = q[0];
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] eu, input logic [6:0] et,
                               input logic [6:0] eh, input logic ee, input int push_k,
                               input logic [8:0] p0, input logic [8:0] p1, input int np);
        logic [2:0] ea;
        logic [6:0] es;
        for (int k = 0; k < 12; k++) begin
            if (k == push_k) begin
                if (np > 0) q.push_back(p0);
                if (np > 1) q.push_back(p1);
            end
            step();
            ea = (k < 4) ? 3'b110 : (k < 8) ? 3'b101 : 3'b011;
            es = (k < 4) ? eu : (k < 8) ? et : eh;
            check_eq($sformatf("%s_an_%0d", tag, k), 32'(an), 32'(ea));
            check_eq($sformatf("%s_seg_%0d", tag, k), 32'(seg), 32'(es));
            check_eq($sformatf("%s_err_%0d", tag, k), 32'(err), 32'(ee));
            check_eq($sformatf("%s_dp_%0d", tag, k), 32'(dp), 32'((k < 4 && ee) ? 1'b0 : 1'b1));
        end
    endtask

    initial begin
        bus.sum       = 8'h00;
        bus.carry     = 1'b0;
        bus.sum_valid = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_an", 32'(an), 32'(3'b111));
        check_eq("rst_seg", 32'(seg), 32'(BL));
        check_eq("rst_dp", 32'(dp), 32'd1);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_ready", 32'(bus.sum_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(bus.sum_ready), 32'd1);
        check_eq("post_rst_an", 32'(an), 32'(3'b111));
        ready_s = bus.sum_ready;

        check_frame("idle",    S0, LZ, LZ, 1'b0, -1, 9'h000, 9'h000, 0);
        check_frame("pre147",  S0, LZ, LZ, 1'b0,  5, 9'h147, 9'h000, 1);
        check_frame("v147",    S7, S4, S1, 1'b0, -1, 9'h000, 9'h000, 0);
        check_frame("v147b",   S7, S4, S1, 1'b0,  2, 9'h012, 9'h034, 2);
        check_frame("v012",    S2, S1, LZ, 1'b0, -1, 9'h000, 9'h000, 0);
        check_frame("v034",    S4, S3, LZ, 1'b0,  0, 9'h00A, 9'h000, 1);
        check_frame("v00A",    SE, LZ, LZ, 1'b1,  0, 9'h005, 9'h000, 1);
        check_frame("v005",    S5, LZ, LZ, 1'b0, -1, 9'h000, 9'h000, 0);

        // Fill the pending buffer, then reset mid-frame before it can reach the display.
        q.push_back(9'h199);
        bus.sum_valid        = 1'b1;
        {bus.carry, bus.sum} = q[0];
        ready_s              = bus.sum_ready;
        step();
        step();
        check_eq("pend_full_ready", 32'(bus.sum_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst2_an", 32'(an), 32'(3'b111));
        check_eq("rst2_seg", 32'(seg), 32'(BL));
        check_eq("rst2_ready", 32'(bus.sum_ready), 32'd1);
        ready_s = bus.sum_ready;
        check_frame("rst2_f0", S0, LZ, LZ, 1'b0, -1, 9'h000, 9'h000, 0);
        check_frame("rst2_f1", S0, LZ, LZ, 1'b0, -1, 9'h000, 9'h000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
